himax_blink: RTL and testbench
==============================

// Module: himax_blink
// PURPOSE
// - Top-level bring-up block for the Himax camera board.
// - Captures the sensor's 4-bit nibble pixel bus and rebuilds 8-bit pixels.
// - Checks frame geometry and reports per-frame status on LEDs, GPIO and a UART byte pair.
// - Also drives the sensor clock and a heartbeat blink.
// PARAMETERS
// NUM_COLS    40  pixels per line
// NUM_ROWS    30  lines per frame
// SENSOR_DIV  2   sensor_clk half-period in clk cycles
// BAUD_DIV    16  clk cycles per UART bit
// HB_BITS     24  heartbeat counter width
// PORTS
// clk         in     1  system clock; must be at least 4x px_clk
// rst         in     1  reset, asynchronous, active-high
// uart_rx     in     1  unused, ignored
// uart_tx     out    1  8N1 status transmitter, idle high
// gpio        out    3  debug: [0] fv_sync, [1] lv_sync, [2] byte-valid pulse
// i2c_scl     inout  1  released (high-Z) at all times
// i2c_sda     inout  1  released (high-Z) at all times
// sensor_clk  out    1  clk / (2*SENSOR_DIV)
// px_clk      in     1  sensor pixel clock, sampled as data
// px_fv       in     1  frame valid
// px_lv       in     1  line valid
// pxd         in     4  pixel nibble
// sensor_led  out    1  toggles at each frame end
// led_red     out    1  sticky frame-size error
// led_green   out    1  heartbeat
// led_blue    out    1  fv_sync (lit during a frame)
// BEHAVIOUR
// Reset values
// - All outputs go low except uart_tx=1; all counters and flags clear.
// Input synchronisation
// - px_clk, px_fv, px_lv and pxd each pass through a 2-FF synchroniser.
// - px_clk rising edge is detected from the synced copy; this is "pe".
// - All pixel logic advances only on cycles where pe=1.
// Nibble assembly
// - On pe with fv&&lv: the first nibble is the high nibble; the second completes the byte.
// - Byte completion: gpio[2] pulses for 1 clk; byte_cnt++; sum += byte (mod 256).
// - Nibble phase clears on pe with lv=0. A half byte left at line end is discarded.
// Frame end (fv falling edge, on pe)
// - frame_cnt (8-bit) increments, wrapping 255->0.
// - sensor_led toggles.
// - If byte_cnt != NUM_COLS*NUM_ROWS, led_red is set; it stays set until rst.
// - If the UART is idle, it queues {frame_cnt (new value), sum}.
// - byte_cnt and sum clear, ready for the next frame.
// - A frame end while the UART is busy does not queue that frame's report; the counters still update.
// Frame start (fv rising)
// - byte_cnt and sum clear again; this covers a frame truncated by reset.
// UART
// - States: IDLE -> START -> DATA (8 bits, LSB first) -> STOP -> next byte or IDLE.
// - Each bit lasts BAUD_DIV clk cycles; the 2-byte burst is sent back to back.
// Heartbeat
// - Free-running HB_BITS counter; led_green = counter MSB.
// Sensor clock
// - sensor_clk toggles every SENSOR_DIV clk cycles.
// Reset mid-operation
// - Everything aborts immediately; uart_tx returns high.
// - The partial frame is ignored; counting resumes at the next fv rise.
// TESTING
// 1. One 40x30 frame, pixel i = i mod 256, 4 blanking cycles per line
//    -> UART sends 0x01 then 0x28; led_red=0; sensor_led=1.
// 2. Frame with a line of 39 pixels
//    -> led_red=1 after fv falls and stays 1 through a following good frame.
// 3. Nibble order: pixels 0xA5, 0x3C -> internal bytes 0xA5, 0x3C
//    -> gpio[2] pulses exactly twice per 2 pixels.
// 4. Second frame sent while the UART is still busy
//    -> no second burst; frame_cnt still reaches 2, visible in the next burst as 0x03.
// 5. rst asserted mid-line -> uart_tx=1, leds 0 at once
//    -> after release, a clean frame reports 0x01, 0x28.
// 6. Idle -> sensor_clk period = 4 clk; led_green toggles every 2^(HB_BITS-1) clk;
//    i2c_scl and i2c_sda are high-Z.

Source files
------------

// File: rtl/himax_blink.sv
// -----------------------------------------------------------------------------
// himax_blink
// Bring-up top level for the Himax camera board.
//   * Synchronises the sensor's nibble pixel bus (px_clk is sampled as data),
//     rebuilds 8-bit pixels (high nibble first) and checks the frame size.
//   * At every frame end reports {frame count, byte checksum} as a two-byte
//     8N1 burst on uart_tx, toggles sensor_led and latches a sticky size
//     error on led_red.
//   * Generates the sensor clock and a heartbeat blink on led_green.
//
// Ports
//   clk         in     system clock (>= 4x px_clk)
//   rst         in     asynchronous active-high reset
//   uart_rx     in     unused
//   uart_tx     out    8N1 status transmitter, idle high
//   gpio[2:0]   out    [0] synced fv, [1] synced lv, [2] byte-valid pulse
//   i2c_scl/sda inout  always released (high-Z)
//   sensor_clk  out    clk / (2*SENSOR_DIV)
//   px_clk      in     sensor pixel clock (sampled)
//   px_fv       in     frame valid
//   px_lv       in     line valid
//   pxd[3:0]    in     pixel nibble
//   sensor_led  out    toggles at each frame end
//   led_red     out    sticky frame-size error
//   led_green   out    heartbeat
//   led_blue    out    lit during a frame (synced fv)
// -----------------------------------------------------------------------------
module himax_blink #(
    parameter int NUM_COLS   = 40,
    parameter int NUM_ROWS   = 30,
    parameter int SENSOR_DIV = 2,
    parameter int BAUD_DIV   = 16,
    parameter int HB_BITS    = 24
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       uart_rx,
    output logic       uart_tx,
    output logic [2:0] gpio,
    inout  wire        i2c_scl,
    inout  wire        i2c_sda,
    output logic       sensor_clk,
    input  logic       px_clk,
    input  logic       px_fv,
    input  logic       px_lv,
    input  logic [3:0] pxd,
    output logic       sensor_led,
    output logic       led_red,
    output logic       led_green,
    output logic       led_blue
);

    localparam int FRAME_BYTES = NUM_COLS * NUM_ROWS;
    localparam int SDIV_W      = (SENSOR_DIV > 1) ? $clog2(SENSOR_DIV) : 1;
    localparam int BAUD_W      = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;

    typedef enum logic [1:0] {
        UART_IDLE  = 2'd0,
        UART_START = 2'd1,
        UART_DATA  = 2'd2,
        UART_STOP  = 2'd3
    } uart_state_e;

    // I2C is not driven by this bring-up image.
    assign i2c_scl = 1'bz;
    assign i2c_sda = 1'bz;

    logic unused_uart_rx;
    assign unused_uart_rx = uart_rx;

    // ------------------------------------------------------------------
    // Input synchronisers: {px_clk, px_fv, px_lv, pxd} all share the same
    // two-stage depth so the data seen at a detected px_clk edge is the
    // data the sensor presented at that edge.
    // ------------------------------------------------------------------
    logic [6:0] sync_meta_q;
    logic [6:0] sync_q;

    // Two-flop synchroniser for the whole pixel bus.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_meta_q <= 7'd0;
            sync_q      <= 7'd0;
        end else begin
            sync_meta_q <= {px_clk, px_fv, px_lv, pxd};
            sync_q      <= sync_meta_q;
        end
    end

    logic       clk_s;
    logic       fv_s;
    logic       lv_s;
    logic [3:0] nib_s;

    assign clk_s = sync_q[6];
    assign fv_s  = sync_q[5];
    assign lv_s  = sync_q[4];
    assign nib_s = sync_q[3:0];

    // ------------------------------------------------------------------
    // Pixel capture / frame accounting
    // ------------------------------------------------------------------
    logic        pxclk_prev_q, pxclk_prev_d;
    logic        fv_prev_q, fv_prev_d;
    logic        frame_active_q, frame_active_d;
    logic        phase_q, phase_d;
    logic [3:0]  hi_nib_q, hi_nib_d;
    logic [15:0] byte_cnt_q, byte_cnt_d;
    logic [7:0]  sum_q, sum_d;
    logic [7:0]  frame_cnt_q, frame_cnt_d;
    logic        byte_stb_q, byte_stb_d;
    logic        sensor_led_q, sensor_led_d;
    logic        led_red_q, led_red_d;

    logic        pe_s;
    logic        fv_rise_s;
    logic        frame_end_s;
    logic [7:0]  new_byte_s;
    logic [7:0]  report_cnt_s;
    logic        send_req_s;
    uart_state_e uart_state_q, uart_state_d;

    assign pe_s      = clk_s & ~pxclk_prev_q;
    assign fv_rise_s = pe_s & fv_s & ~fv_prev_q;
    // A frame only ends if we saw it start; this drops a frame that was
    // already in flight when reset released.
    assign frame_end_s  = pe_s & ~fv_s & fv_prev_q & frame_active_q;
    assign new_byte_s   = {hi_nib_q, nib_s};
    assign report_cnt_s = frame_cnt_q + 8'd1;
    assign send_req_s   = frame_end_s & (uart_state_q == UART_IDLE);

    // Next-state logic for nibble assembly and frame bookkeeping.
    always_comb begin
        pxclk_prev_d   = clk_s;
        fv_prev_d      = fv_prev_q;
        frame_active_d = frame_active_q;
        phase_d        = phase_q;
        hi_nib_d       = hi_nib_q;
        byte_cnt_d     = byte_cnt_q;
        sum_d          = sum_q;
        frame_cnt_d    = frame_cnt_q;
        byte_stb_d     = 1'b0;
        sensor_led_d   = sensor_led_q;
        led_red_d      = led_red_q;

        if (pe_s) begin
            fv_prev_d = fv_s;
        end else begin
            fv_prev_d = fv_prev_q;
        end

        if (pe_s && fv_s && lv_s) begin
            if (phase_q == 1'b0) begin
                hi_nib_d = nib_s;
                phase_d  = 1'b1;
            end else begin
                phase_d    = 1'b0;
                byte_stb_d = 1'b1;
                // Saturate so an oversize frame can never alias to a good count.
                byte_cnt_d = (byte_cnt_q == 16'hFFFF) ? byte_cnt_q : byte_cnt_q + 16'd1;
                sum_d      = sum_q + new_byte_s;
            end
        end else if (pe_s && !lv_s) begin
            // Line end discards any dangling high nibble.
            phase_d = 1'b0;
        end else begin
            phase_d = phase_q;
        end

        if (fv_rise_s) begin
            frame_active_d = 1'b1;
            byte_cnt_d     = 16'd0;
            sum_d          = 8'd0;
        end else if (frame_end_s) begin
            frame_active_d = 1'b0;
            frame_cnt_d    = report_cnt_s;
            sensor_led_d   = ~sensor_led_q;
            byte_cnt_d     = 16'd0;
            sum_d          = 8'd0;
            if (byte_cnt_q != 16'(FRAME_BYTES)) begin
                led_red_d = 1'b1;
            end else begin
                led_red_d = led_red_q;
            end
        end else begin
            frame_active_d = frame_active_q;
        end
    end

    // Pixel / frame state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pxclk_prev_q   <= 1'b0;
            fv_prev_q      <= 1'b1;   // a frame already high at release is not a start
            frame_active_q <= 1'b0;
            phase_q        <= 1'b0;
            hi_nib_q       <= 4'd0;
            byte_cnt_q     <= 16'd0;
            sum_q          <= 8'd0;
            frame_cnt_q    <= 8'd0;
            byte_stb_q     <= 1'b0;
            sensor_led_q   <= 1'b0;
            led_red_q      <= 1'b0;
        end else begin
            pxclk_prev_q   <= pxclk_prev_d;
            fv_prev_q      <= fv_prev_d;
            frame_active_q <= frame_active_d;
            phase_q        <= phase_d;
            hi_nib_q       <= hi_nib_d;
            byte_cnt_q     <= byte_cnt_d;
            sum_q          <= sum_d;
            frame_cnt_q    <= frame_cnt_d;
            byte_stb_q     <= byte_stb_d;
            sensor_led_q   <= sensor_led_d;
            led_red_q      <= led_red_d;
        end
    end

    // ------------------------------------------------------------------
    // UART transmitter: sends {report count, checksum} back to back.
    // ------------------------------------------------------------------
    logic [BAUD_W-1:0] baud_q, baud_d;
    logic [2:0]        bit_q, bit_d;
    logic              second_q, second_d;
    logic [7:0]        shift_q, shift_d;
    logic [7:0]        pend_q, pend_d;
    logic              tx_q, tx_d;
    logic              baud_last_s;

    assign baud_last_s = (baud_q == BAUD_W'(BAUD_DIV - 1));

    // UART next-state and line-level logic.
    always_comb begin
        uart_state_d = uart_state_q;
        baud_d       = baud_q;
        bit_d        = bit_q;
        second_d     = second_q;
        shift_d      = shift_q;
        pend_d       = pend_q;
        tx_d         = 1'b1;

        case (uart_state_q)
            UART_IDLE: begin
                if (send_req_s) begin
                    uart_state_d = UART_START;
                    baud_d       = '0;
                    shift_d      = report_cnt_s;
                    pend_d       = sum_q;
                    second_d     = 1'b0;
                end else begin
                    uart_state_d = UART_IDLE;
                end
            end
            UART_START: begin
                if (baud_last_s) begin
                    baud_d       = '0;
                    bit_d        = 3'd0;
                    uart_state_d = UART_DATA;
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end
            UART_DATA: begin
                if (baud_last_s) begin
                    baud_d  = '0;
                    shift_d = {1'b0, shift_q[7:1]};
                    if (bit_q == 3'd7) begin
                        uart_state_d = UART_STOP;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end
            UART_STOP: begin
                if (baud_last_s) begin
                    baud_d = '0;
                    if (second_q == 1'b0) begin
                        second_d     = 1'b1;
                        shift_d      = pend_q;
                        uart_state_d = UART_START;
                    end else begin
                        uart_state_d = UART_IDLE;
                    end
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end
            default: begin
                uart_state_d = UART_IDLE;
            end
        endcase

        // Line level follows the state being entered so tx_q is aligned
        // with uart_state_q.
        case (uart_state_d)
            UART_START: tx_d = 1'b0;
            UART_DATA:  tx_d = shift_d[0];
            default:    tx_d = 1'b1;
        endcase
    end

    // UART registers; line returns high on reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            uart_state_q <= UART_IDLE;
            baud_q       <= '0;
            bit_q        <= 3'd0;
            second_q     <= 1'b0;
            shift_q      <= 8'd0;
            pend_q       <= 8'd0;
            tx_q         <= 1'b1;
        end else begin
            uart_state_q <= uart_state_d;
            baud_q       <= baud_d;
            bit_q        <= bit_d;
            second_q     <= second_d;
            shift_q      <= shift_d;
            pend_q       <= pend_d;
            tx_q         <= tx_d;
        end
    end

    // ------------------------------------------------------------------
    // Heartbeat and sensor clock
    // ------------------------------------------------------------------
    logic [HB_BITS-1:0] hb_q, hb_d;
    logic [SDIV_W-1:0]  sdiv_q, sdiv_d;
    logic               sclk_q, sclk_d;

    // Free-running heartbeat and sensor-clock divider next state.
    always_comb begin
        hb_d = hb_q + HB_BITS'(1);
        if (sdiv_q == SDIV_W'(SENSOR_DIV - 1)) begin
            sdiv_d = '0;
            sclk_d = ~sclk_q;
        end else begin
            sdiv_d = sdiv_q + SDIV_W'(1);
            sclk_d = sclk_q;
        end
    end

    // Heartbeat and sensor-clock registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hb_q   <= '0;
            sdiv_q <= '0;
            sclk_q <= 1'b0;
        end else begin
            hb_q   <= hb_d;
            sdiv_q <= sdiv_d;
            sclk_q <= sclk_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs (all straight from registers)
    // ------------------------------------------------------------------
    assign uart_tx    = tx_q;
    assign gpio       = {byte_stb_q, lv_s, fv_s};
    assign sensor_clk = sclk_q;
    assign sensor_led = sensor_led_q;
    assign led_red    = led_red_q;
    assign led_green  = hb_q[HB_BITS-1];
    assign led_blue   = fv_s;

endmodule

// File: tb/tb_himax_blink.sv
module tb_himax_blink;

    localparam int NC   = 40;
    localparam int NR   = 30;
    localparam int BAUD = 16;
    localparam int HB   = 6;

    logic       clk;
    logic       rst;
    logic       uart_rx;
    logic       px_clk;
    logic       px_fv;
    logic       px_lv;
    logic [3:0] pxd;
    wire        uart_tx;
    wire [2:0]  gpio;
    wire        i2c_scl;
    wire        i2c_sda;
    wire        sensor_clk;
    wire        sensor_led;
    wire        led_red;
    wire        led_green;
    wire        led_blue;

    himax_blink #(
        .NUM_COLS  (NC),
        .NUM_ROWS  (NR),
        .SENSOR_DIV(2),
        .BAUD_DIV  (BAUD),
        .HB_BITS   (HB)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .uart_rx   (uart_rx),
        .uart_tx   (uart_tx),
        .gpio      (gpio),
        .i2c_scl   (i2c_scl),
        .i2c_sda   (i2c_sda),
        .sensor_clk(sensor_clk),
        .px_clk    (px_clk),
        .px_fv     (px_fv),
        .px_lv     (px_lv),
        .pxd       (pxd),
        .sensor_led(sensor_led),
        .led_red   (led_red),
        .led_green (led_green),
        .led_blue  (led_blue)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int pulse_cnt = 0;

    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (gpio[2] === 1'b1) pulse_cnt <= pulse_cnt + 1;

    // Scoreboard and reference model state.
    logic [7:0] exp_q[$];
    int         frame_cnt_m = 0;
    logic       red_m  = 1'b0;
    logic       sled_m = 1'b0;
    int         busy_until = 0;

    // Frame description consumed by drive_frame.
    int         line_len[$];
    bit         line_odd[$];
    logic [7:0] pix_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // UART monitor: decodes every byte and compares with the scoreboard.
    initial begin : uart_mon
        logic [7:0] b;
        logic [7:0] e;
        forever begin
            @(negedge uart_tx);
            repeat (BAUD / 2) @(negedge clk);
            check("uart_start_bit", {31'd0, uart_tx}, 32'd0);
            for (int i = 0; i < 8; i++) begin
                repeat (BAUD) @(negedge clk);
                b[i] = uart_tx;
            end
            repeat (BAUD) @(negedge clk);
            check("uart_stop_bit", {31'd0, uart_tx}, 32'd1);
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL uart_unexpected: got 0x%0h expected no byte", b);
            end else begin
                e = exp_q.pop_front();
                check("uart_byte", {24'd0, b}, {24'd0, e});
            end
        end
    end

    initial begin : watchdog
        #5000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    // One px_clk period (4 clk): data changes with the falling edge.
    task automatic px(input logic fv, input logic lv, input logic [3:0] n);
        @(negedge clk);
        px_clk = 1'b0; px_fv = fv; px_lv = lv; pxd = n;
        @(negedge clk);
        @(negedge clk);
        px_clk = 1'b1;
        @(negedge clk);
    endtask

    task automatic clear_frame();
        line_len.delete();
        line_odd.delete();
        pix_q.delete();
    endtask

    // Counter-pattern frame, pixel i = i mod 256; short_line (>=0) loses one pixel.
    task automatic build_counter_frame(input int short_line);
        int k;
        clear_frame();
        k = 0;
        for (int l = 0; l < NR; l++) begin
            line_len.push_back((l == short_line) ? NC - 1 : NC);
            line_odd.push_back(1'b0);
            for (int p = 0; p < line_len[l]; p++) begin
                pix_q.push_back(8'(k));
                k++;
            end
        end
    endtask

    task automatic build_random_frame();
        int rows;
        clear_frame();
        rows = $urandom_range(1, 3);
        for (int l = 0; l < rows; l++) begin
            line_len.push_back($urandom_range(1, 12));
            line_odd.push_back(1'($urandom_range(0, 1)));
            for (int p = 0; p < line_len[l]; p++) pix_q.push_back(8'($urandom));
        end
    endtask

    task automatic drive_frame(input string tag, input bit expect_busy);
        int         bytes_m;
        logic [7:0] sum_m;
        int         base;
        int         idx;
        logic [7:0] b;
        bytes_m = 0; sum_m = 8'd0; idx = 0;
        base = pulse_cnt;
        px(1'b0, 1'b0, 4'd0);
        px(1'b1, 1'b0, 4'd0);
        px(1'b1, 1'b0, 4'd0);
        check({tag, "_led_blue_in_frame"}, {31'd0, led_blue}, 32'd1);
        check({tag, "_gpio0_in_frame"}, {31'd0, gpio[0]}, 32'd1);
        for (int l = 0; l < line_len.size(); l++) begin
            for (int p = 0; p < line_len[l]; p++) begin
                b = pix_q[idx];
                idx++;
                px(1'b1, 1'b1, b[7:4]);
                px(1'b1, 1'b1, b[3:0]);
                bytes_m++;
                sum_m = sum_m + b;
            end
            if (line_odd[l]) px(1'b1, 1'b1, 4'($urandom));
            repeat (4) px(1'b1, 1'b0, 4'd0);
        end
        if (!expect_busy) begin
            while (cyc < busy_until) px(1'b1, 1'b0, 4'd0);
        end
        px(1'b0, 1'b0, 4'd0);
        // Reference model of the frame-end rules.
        frame_cnt_m = (frame_cnt_m + 1) % 256;
        sled_m = ~sled_m;
        if (bytes_m != NC * NR) red_m = 1'b1;
        if (cyc >= busy_until) begin
            exp_q.push_back(8'(frame_cnt_m));
            exp_q.push_back(sum_m);
            busy_until = cyc + 2 * 10 * BAUD + 16;
        end
        px(1'b0, 1'b0, 4'd0);
        check({tag, "_led_red"}, {31'd0, led_red}, {31'd0, red_m});
        check({tag, "_sensor_led"}, {31'd0, sensor_led}, {31'd0, sled_m});
        check({tag, "_led_blue_after"}, {31'd0, led_blue}, 32'd0);
        check({tag, "_byte_pulses"}, 32'(pulse_cnt - base), 32'(bytes_m));
    endtask

    task automatic wait_idle(input string tag);
        int g;
        g = 0;
        while ((exp_q.size() != 0 || cyc < busy_until) && g < 5000) begin
            @(negedge clk);
            g++;
        end
        check({tag, "_uart_drained"}, {31'd0, (g < 5000)}, 32'd1);
    endtask

    // Counts clk cycles until the chosen output changes (-1 on timeout).
    task automatic wait_change(input int which, input int limit, output int n);
        logic v0;
        n = -1;
        v0 = (which == 0) ? sensor_clk : led_green;
        for (int i = 1; i <= limit; i++) begin
            @(negedge clk);
            if (((which == 0) ? sensor_clk : led_green) !== v0) begin
                n = i;
                break;
            end
        end
    endtask

    initial begin : stim
        int n;
        rst = 1'b1; uart_rx = 1'b1;
        px_clk = 1'b0; px_fv = 1'b0; px_lv = 1'b0; pxd = 4'd0;
        repeat (4) @(negedge clk);
        check("rst_uart_tx", {31'd0, uart_tx}, 32'd1);
        check("rst_gpio", {29'd0, gpio}, 32'd0);
        check("rst_leds", {28'd0, sensor_led, led_red, led_green, led_blue}, 32'd0);
        check("rst_sensor_clk", {31'd0, sensor_clk}, 32'd0);
        rst = 1'b0;

        // Idle behaviour: sensor clock and heartbeat rates.
        wait_change(0, 20, n);
        wait_change(0, 20, n);
        check("sensor_clk_high_time", 32'(n), 32'd2);
        wait_change(0, 20, n);
        check("sensor_clk_low_time", 32'(n), 32'd2);
        wait_change(1, 200, n);
        wait_change(1, 200, n);
        check("led_green_half_period", 32'(n), 32'd1 << (HB - 1));
        wait_change(1, 200, n);
        check("led_green_half_period2", 32'(n), 32'd1 << (HB - 1));

        // Good 40x30 frame.
        build_counter_frame(-1);
        drive_frame("good1", 1'b0);

        // Frame with one 39-pixel line, then a good frame (error stays).
        build_counter_frame(5);
        drive_frame("short_line", 1'b0);
        build_counter_frame(-1);
        drive_frame("good_after_err", 1'b0);

        // Nibble order.
        clear_frame();
        line_len.push_back(2); line_odd.push_back(1'b0);
        pix_q.push_back(8'hA5); pix_q.push_back(8'h3C);
        drive_frame("nibble", 1'b0);

        // Frame end while UART busy: short frame right after a good one.
        build_counter_frame(-1);
        drive_frame("busy_a", 1'b0);
        clear_frame();
        line_len.push_back(1); line_odd.push_back(1'b0); pix_q.push_back(8'h11);
        drive_frame("busy_b", 1'b1);
        build_random_frame();
        drive_frame("busy_c", 1'b0);

        // Randomized frames with odd trailing nibbles.
        for (int r = 0; r < 6; r++) begin
            build_random_frame();
            drive_frame("random", 1'b0);
        end

        // Reset in the middle of a line.
        wait_idle("pre_reset");
        px(1'b0, 1'b0, 4'd0);
        px(1'b1, 1'b0, 4'd0);
        px(1'b1, 1'b0, 4'd0);
        for (int p = 0; p < 5; p++) begin
            px(1'b1, 1'b1, 4'h7);
            px(1'b1, 1'b1, 4'h2);
        end
        px(1'b1, 1'b1, 4'h9);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("midrst_uart_tx", {31'd0, uart_tx}, 32'd1);
        check("midrst_leds", {28'd0, sensor_led, led_red, led_green, led_blue}, 32'd0);
        check("midrst_gpio", {29'd0, gpio}, 32'd0);
        frame_cnt_m = 0; red_m = 1'b0; sled_m = 1'b0; busy_until = 0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        for (int p = 0; p < 5; p++) begin
            px(1'b1, 1'b1, 4'h1);
            px(1'b1, 1'b1, 4'h2);
        end
        repeat (4) px(1'b1, 1'b0, 4'd0);
        px(1'b0, 1'b0, 4'd0);
        repeat (3) px(1'b0, 1'b0, 4'd0);
        check("partial_frame_ignored_sled", {31'd0, sensor_led}, 32'd0);
        check("partial_frame_ignored_red", {31'd0, led_red}, 32'd0);
        build_counter_frame(-1);
        drive_frame("post_reset", 1'b0);

        wait_idle("final");
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
